fc_seq_ctrl: RTL
================

Name: fc_seq_ctrl

Overview:
- Sequencer for a time-multiplexed fully-connected stack: one shared MAC datapath evaluates layers 256->128, 128->84 and 84->10 in order.
- Per neuron it clears the accumulator, streams one input/weight pair per cycle, then issues a write-back strobe carrying the truncation shift for that layer.
- Sits between the conv/pool front end (start) and the FC MAC plus activation/weight buffers; replaces fully parallel FC instances when area matters.

Parameters:
- WIDTH, 8, activation/weight width; sets the write-back shift.
- W_ADDR_W, 16, weight address width; must cover the 44360 total weights.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  run request, sampled in IDLE only
- stall  input  1  memory not ready; freezes the sequencer
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  one-cycle pulse at the end of the run
- layer_idx  output  2  current layer: 0 = 256->128, 1 = 128->84, 2 = 84->10
- in_idx  output  8  input element index (activation read address)
- out_idx  output  7  neuron index (write-back address)
- w_addr  output  W_ADDR_W  flat weight address
- mac_clr  output  1  clear accumulator
- mac_en  output  1  accumulate x[in_idx]*w[w_addr]
- wb_en  output  1  write truncated accumulator to out_idx
- wb_shift  output  5  LSB of the slice to keep: WIDTH+clog2(N_in)+1

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-run aborts immediately; no done pulse.
- States: IDLE, CLR, MAC, WB, DONE.
- IDLE: start=1 -> CLR next cycle. layer, out_idx, in_idx and w_addr are zeroed.
- CLR: mac_clr=1 for one cycle, then MAC.
- MAC: mac_en=1 for N_in cycles; in_idx runs 0..N_in-1; w_addr increments by 1 each cycle.
  - w_addr is a running flat address, not recomputed per layer.
  - At in_idx==N_in-1 -> WB.
- WB: wb_en=1 for one cycle with the current out_idx and wb_shift; in_idx returns to 0.
  - out_idx < N_out-1: out_idx++ -> CLR.
  - Last neuron, layer < 2: layer++, out_idx=0 -> CLR.
  - Last neuron, layer 2 -> DONE.
- DONE: done=1 and busy=1 for one cycle -> IDLE.
- Latency: a layer takes N_out*(N_in+2) cycles. A full run has 44804 CLR/MAC/WB cycles plus 1 DONE cycle.
- stall=1 (any state except IDLE/DONE):
  - State and counters hold.
  - mac_clr, mac_en and wb_en are forced 0; indices keep their values.
  - Sequencing resumes exactly where it stopped.
- start while busy is ignored. start and stall together in IDLE: start is still accepted.
- Wrap-around: w_addr never exceeds 44359 and is never wrapped. in_idx width covers 255; out_idx width covers 127.

Optional Feature:
- FC_PERF_EN: adds outputs perf_busy_cyc[31:0] and perf_stall_cyc[31:0].
  - Both cleared when start is accepted.
  - They count busy cycles and stalled busy cycles respectively; values are held after done until the next start.
- Without the macro these ports and counters do not exist.

Decomposition:
- Package fc_seq_pkg:
  - state enum;
  - FC_NUM_LAYERS=3;
  - constant arrays FC_N_IN={256,128,84} and FC_N_OUT={128,84,10};
  - FC_W_TOTAL=44360.
- Sub-module fc_layer_cfg (combinational): layer_idx -> n_in, n_out, wb_shift.

Test Plan:
- start pulse, no stall -> busy for 44805 cycles.
  - done pulses once; 128+84+10 wb_en pulses total.
  - Last mac_en cycle has w_addr=44359.
- Layer transitions -> first WB of layer 0 has wb_shift=17; layer 1 has 16; layer 2 has 16.
  - layer_idx steps 0->1->2.
  - Layer 0 CLR-to-CLR neuron spacing is 258 cycles.
- Random stall pattern (about 30% duty) -> mac_en/wb_en sequence identical to the unstalled run, only stretched.
  - done is delayed by exactly the number of stalled cycles.
- start held high through the run plus an extra start mid-run -> only one run.
  - A new run begins in the cycle after DONE if start is still high.
- rst_n asserted during layer 1 MAC -> all outputs 0 asynchronously, no done pulse.
  - A subsequent start runs a full, correct sequence.
- With FC_PERF_EN, 100 injected stall cycles -> perf_busy_cyc=44905 and perf_stall_cyc=100.

Source files
------------

// File: rtl/fc_seq_pkg.sv
// Shared types and layer geometry for the time-multiplexed FC sequencer.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_MAC,
    ST_WB,
    ST_DONE
  } fc_state_e;

  localparam int unsigned FC_NUM_LAYERS = 3;
  localparam int unsigned FC_N_IN  [FC_NUM_LAYERS] = '{256, 128, 84};
  localparam int unsigned FC_N_OUT [FC_NUM_LAYERS] = '{128, 84, 10};
  localparam int unsigned FC_W_TOTAL = 44360;

  // LSB of the accumulator slice kept on write-back.
  function automatic int unsigned fc_wb_shift(input int unsigned width, input int unsigned n_in);
    return width + $clog2(n_in) + 1;
  endfunction

endpackage

// File: rtl/fc_layer_cfg.sv
// Combinational layer lookup: layer index -> fan-in, fan-out, write-back shift.
module fc_layer_cfg
  import fc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0] i_layer,
  output logic [8:0] o_n_in,
  output logic [7:0] o_n_out,
  output logic [4:0] o_wb_shift
);

  always_comb begin
    o_n_in     = 9'(FC_N_IN[2]);
    o_n_out    = 8'(FC_N_OUT[2]);
    o_wb_shift = 5'(fc_wb_shift(WIDTH, FC_N_IN[2]));
    case (i_layer)
      2'd0: begin
        o_n_in     = 9'(FC_N_IN[0]);
        o_n_out    = 8'(FC_N_OUT[0]);
        o_wb_shift = 5'(fc_wb_shift(WIDTH, FC_N_IN[0]));
      end
      2'd1: begin
        o_n_in     = 9'(FC_N_IN[1]);
        o_n_out    = 8'(FC_N_OUT[1]);
        o_wb_shift = 5'(fc_wb_shift(WIDTH, FC_N_IN[1]));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer driving one shared MAC through the 256->128->84->10 FC stack.
// Optional FC_PERF_EN adds busy/stall cycle counters.
module fc_seq_ctrl
  import fc_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned W_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [1:0]          layer_idx,
  output logic [7:0]          in_idx,
  output logic [6:0]          out_idx,
  output logic [W_ADDR_W-1:0] w_addr,
  output logic                mac_clr,
  output logic                mac_en,
  output logic                wb_en,
  output logic [4:0]          wb_shift
`ifdef FC_PERF_EN
  ,
  output logic [31:0]         perf_busy_cyc,
  output logic [31:0]         perf_stall_cyc
`endif
);

  localparam logic [W_ADDR_W-1:0] W_LAST = W_ADDR_W'(FC_W_TOTAL - 1);

  fc_state_e             r_state, w_next;
  logic [1:0]            r_layer;
  logic [7:0]            r_in_idx;
  logic [6:0]            r_out_idx;
  logic [W_ADDR_W-1:0]   r_w_addr;
  logic [8:0]            w_n_in;
  logic [7:0]            w_n_out;
  logic [4:0]            w_wb_shift;
  logic                  w_adv, w_last_in, w_last_out, w_last_layer;

  fc_layer_cfg #(.WIDTH(WIDTH)) u_cfg (
    .i_layer    (r_layer),
    .o_n_in     (w_n_in),
    .o_n_out    (w_n_out),
    .o_wb_shift (w_wb_shift)
  );

  assign w_adv        = ~stall;
  assign w_last_in    = ({1'b0, r_in_idx} == (w_n_in - 9'd1));
  assign w_last_out   = ({1'b0, r_out_idx} == (w_n_out - 8'd1));
  assign w_last_layer = (r_layer == 2'(FC_NUM_LAYERS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_CLR;
      ST_CLR:  if (w_adv) w_next = ST_MAC;
      ST_MAC:  if (w_adv && w_last_in) w_next = ST_WB;
      ST_WB:   if (w_adv) w_next = (w_last_out && w_last_layer) ? ST_DONE : ST_CLR;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // w_addr is a running address across layers; it saturates on the final weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_layer   <= '0;
      r_in_idx  <= '0;
      r_out_idx <= '0;
      r_w_addr  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_layer   <= '0;
          r_in_idx  <= '0;
          r_out_idx <= '0;
          r_w_addr  <= '0;
        end
        ST_MAC: if (w_adv) begin
          if (!w_last_in)         r_in_idx <= r_in_idx + 8'd1;
          if (r_w_addr != W_LAST) r_w_addr <= r_w_addr + W_ADDR_W'(1);
        end
        ST_WB: if (w_adv) begin
          r_in_idx <= '0;
          if (!w_last_out) begin
            r_out_idx <= r_out_idx + 7'd1;
          end else if (!w_last_layer) begin
            r_layer   <= r_layer + 2'd1;
            r_out_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    done      = (r_state == ST_DONE);
    mac_clr   = (r_state == ST_CLR) && w_adv;
    mac_en    = (r_state == ST_MAC) && w_adv;
    wb_en     = (r_state == ST_WB)  && w_adv;
    wb_shift  = (r_state == ST_WB) ? w_wb_shift : '0;
    layer_idx = r_layer;
    in_idx    = r_in_idx;
    out_idx   = r_out_idx;
    w_addr    = r_w_addr;
  end

`ifdef FC_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (r_state == ST_IDLE) begin
      if (start) begin
        perf_busy_cyc  <= '0;
        perf_stall_cyc <= '0;
      end
    end else begin
      perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (stall && r_state != ST_DONE) perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule
